// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU datapath types. Holds the vector memory addressing
//               modes, the lane-memory sequencer state encoding and a helper
//               for sizing lane index fields.
// Revision    : 1.0 - initial vector memory sequencer support
// ============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Vector memory addressing mode (encoding is fixed by the decoder)
    typedef enum logic [1:0] {
        VM_UNIT    = 2'b00,
        VM_STRIDED = 2'b01,
        VM_GATHER  = 2'b10
    } vmem_mode_t;

    // Lane-memory sequencer states
    typedef enum logic [1:0] {
        VS_IDLE  = 2'b00,
        VS_ISSUE = 2'b01,
        VS_DONE  = 2'b10
    } vseq_state_t;

    // Width of a lane index; a single-lane build still needs one bit
    function automatic int lane_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_priority_picker.sv
`default_nettype none
// ============================================================================
// Module      : lane_priority_picker
// Description : Picks the lowest-index pending lane.
//   pending  in   NUM_LANES   lanes still waiting for a cache access
//   grant    out  NUM_LANES   one-hot grant of the lowest set pending bit
//   index    out  IDX_W       binary index of the granted lane
//   any      out  1           at least one lane pending
// Revision    : 1.0 - initial version
// ============================================================================
module lane_priority_picker
    import cpu_types_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int IDX_W     = lane_idx_w(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] pending,
    output logic [NUM_LANES-1:0] grant,
    output logic [IDX_W-1:0]     index,
    output logic                 any
);

    // Scan from the top down so the last hit written is the lowest index
    always_comb begin
        grant = '0;
        index = '0;
        any   = |pending;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                index    = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/simt_vector_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : simt_vector_mem_sequencer
// Description : Lane-memory sequencer for the SIMD/SIMT datapath. Accepts one
//               vector load/store, computes every lane address (unit, strided
//               or gather) at accept, then serialises the active lanes onto
//               the scalar data-cache port, merging load data into rdata.
//   CLK, nRST                 clock (rising) / async active-low reset
//   req_valid/req_ready       request handshake (ready only when idle)
//   req_write, req_mode       store/load select, addressing mode
//   req_base, req_stride      base address and byte stride
//   req_addr, req_wdata       per-lane gather addresses and store data
//   req_mask                  lane-active mask
//   abort                     cancel current op after outstanding access
//   busy, done, rdata         status, completion pulse, merged load data
//   dREN, dWEN, daddr, dstore scalar cache request
//   dload, dhit               scalar cache response
// Revision    : 1.0 - initial version
// ============================================================================
module simt_vector_mem_sequencer
    import cpu_types_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int WORD_W     = 32,
    parameter int ELEM_BYTES = 4
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [1:0]                  req_mode,
    input  logic [WORD_W-1:0]           req_base,
    input  logic [WORD_W-1:0]           req_stride,
    input  logic [NUM_LANES*WORD_W-1:0] req_addr,
    input  logic [NUM_LANES*WORD_W-1:0] req_wdata,
    input  logic [NUM_LANES-1:0]        req_mask,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic [NUM_LANES*WORD_W-1:0] rdata,
    output logic                        dREN,
    output logic                        dWEN,
    output logic [WORD_W-1:0]           daddr,
    output logic [WORD_W-1:0]           dstore,
    input  logic [WORD_W-1:0]           dload,
    input  logic                        dhit
);

    localparam int IDX_W = lane_idx_w(NUM_LANES);

    vseq_state_t                 r_state;
    vseq_state_t                 w_state_next;
    logic                        r_write;
    logic                        r_abort;
    logic [NUM_LANES-1:0]        r_pending;
    logic [NUM_LANES-1:0]        w_grant;
    logic [IDX_W-1:0]            w_idx;
    logic                        w_any;
    logic [WORD_W-1:0]           r_addr      [NUM_LANES];
    logic [WORD_W-1:0]           r_wdata     [NUM_LANES];
    logic [WORD_W-1:0]           w_lane_addr [NUM_LANES];
    logic [NUM_LANES*WORD_W-1:0] r_rdata;
    logic                        w_accept;
    logic                        w_hit;

    assign req_ready = (r_state == VS_IDLE);
    assign w_accept  = req_valid & req_ready;
    assign w_hit     = (r_state == VS_ISSUE) & dhit;
    assign rdata     = r_rdata;

    lane_priority_picker #(
        .NUM_LANES (NUM_LANES),
        .IDX_W     (IDX_W)
    ) u_picker (
        .pending (r_pending),
        .grant   (w_grant),
        .index   (w_idx),
        .any     (w_any)
    );

    // ------------------------------------------------------------------------
    // Per-lane address generation, request latching and load merge
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam logic [WORD_W-1:0] c_lane_num  = WORD_W'(i);
        localparam logic [WORD_W-1:0] c_unit_step = WORD_W'(ELEM_BYTES * i);

        // Sums and products truncate to WORD_W, giving wrap-around addressing
        always_comb begin
            case (vmem_mode_t'(req_mode))
                VM_UNIT:    w_lane_addr[i] = req_base + c_unit_step;
                VM_STRIDED: w_lane_addr[i] = req_base + req_stride * c_lane_num;
                default:    w_lane_addr[i] = req_addr[i*WORD_W +: WORD_W];
            endcase
        end

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                r_addr[i]  <= '0;
                r_wdata[i] <= '0;
            end else if (w_accept) begin
                r_addr[i]  <= w_lane_addr[i];
                r_wdata[i] <= req_wdata[i*WORD_W +: WORD_W];
            end
        end

        // Only the granted lane of a load takes cache data; others keep value
        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                r_rdata[i*WORD_W +: WORD_W] <= '0;
            end else if (w_hit && !r_write && w_grant[i]) begin
                r_rdata[i*WORD_W +: WORD_W] <= dload;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= VS_IDLE;
            r_write   <= 1'b0;
            r_abort   <= 1'b0;
            r_pending <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_write   <= req_write;
                r_pending <= req_mask;
                r_abort   <= 1'b0;
            end else begin
                if (w_hit) begin
                    r_pending <= r_pending & ~w_grant;
                end
                // Abort cannot cancel an access already on the port, so it is
                // remembered until that access completes
                if (r_state == VS_ISSUE && abort) begin
                    r_abort <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next state and cache-port outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != VS_IDLE);
        done         = 1'b0;
        dREN         = 1'b0;
        dWEN         = 1'b0;
        daddr        = '0;
        dstore       = '0;
        case (r_state)
            VS_IDLE: begin
                if (w_accept) begin
                    w_state_next = (req_mask == '0) ? VS_DONE : VS_ISSUE;
                end
            end
            VS_ISSUE: begin
                dREN   = w_any & ~r_write;
                dWEN   = w_any & r_write;
                daddr  = r_addr[w_idx];
                dstore = r_wdata[w_idx];
                if (dhit) begin
                    if (abort || r_abort) begin
                        w_state_next = VS_IDLE;
                    end else if ((r_pending & ~w_grant) == '0) begin
                        w_state_next = VS_DONE;
                    end
                end
            end
            VS_DONE: begin
                done         = 1'b1;
                w_state_next = VS_IDLE;
            end
            default: begin
                w_state_next = VS_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_simt_vector_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_simt_vector_mem_sequencer
// Description : Directed, table-driven bench for simt_vector_mem_sequencer
//               with hand-written wait-state, abort and reset sequences.
// Revision    : 1.0 - initial version
// ============================================================================
module tb_simt_vector_mem_sequencer;

    localparam int NL = 4;
    localparam int W  = 32;

    logic            CLK = 1'b0;
    logic            nRST;
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [1:0]      req_mode;
    logic [W-1:0]    req_base;
    logic [W-1:0]    req_stride;
    logic [NL*W-1:0] req_addr;
    logic [NL*W-1:0] req_wdata;
    logic [NL-1:0]   req_mask;
    logic            abort;
    logic            busy;
    logic            done;
    logic [NL*W-1:0] rdata;
    logic            dREN;
    logic            dWEN;
    logic [W-1:0]    daddr;
    logic [W-1:0]    dstore;
    logic [W-1:0]    dload;
    logic            dhit;

    simt_vector_mem_sequencer #(
        .NUM_LANES  (NL),
        .WORD_W     (W),
        .ELEM_BYTES (4)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_mode   (req_mode),
        .req_base   (req_base),
        .req_stride (req_stride),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_mask   (req_mask),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .dREN       (dREN),
        .dWEN       (dWEN),
        .daddr      (daddr),
        .dstore     (dstore),
        .dload      (dload),
        .dhit       (dhit)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic                 write;
        logic [1:0]           mode;
        logic [W-1:0]         base;
        logic [W-1:0]         stride;
        logic [NL-1:0][W-1:0] gaddr;
        logic [NL-1:0][W-1:0] wdata;
        logic [NL-1:0]        mask;
        int                   n_acc;
        logic [NL-1:0][W-1:0] exp_addr;   // expected daddr, in access order
        logic [NL-1:0][W-1:0] exp_st;     // expected dstore, in access order
        logic [NL-1:0][W-1:0] exp_rdata;
    } vec_t;

    vec_t tv [6];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [NL*W-1:0] act, input logic [NL*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic wr, input logic [1:0] md, input logic [W-1:0] b,
                             input logic [W-1:0] s, input logic [NL*W-1:0] ga,
                             input logic [NL*W-1:0] wd, input logic [NL-1:0] m);
        @(negedge CLK);
        req_valid  = 1'b1;
        req_write  = wr;
        req_mode   = md;
        req_base   = b;
        req_stride = s;
        req_addr   = ga;
        req_wdata  = wd;
        req_mask   = m;
        #1 chk("ready_at_req", {127'd0, req_ready}, 128'd1);
        @(negedge CLK);
        // Garbage afterwards: the op must run from the latched copy
        req_valid  = 1'b0;
        req_write  = ~wr;
        req_mode   = 2'b10;
        req_base   = 32'hDEAD0000;
        req_stride = 32'h00000100;
        req_addr   = {NL{32'hBAD0BAD0}};
        req_wdata  = {NL{32'h0BAD0BAD}};
        req_mask   = 4'b1111;
    endtask

    task automatic run_vec(input int vi);
        vec_t v;
        v = tv[vi];
        drive_req(v.write, v.mode, v.base, v.stride, v.gaddr, v.wdata, v.mask);
        for (int k = 0; k < v.n_acc; k++) begin
            if (k > 0) @(negedge CLK);
            dhit  = 1'b1;
            dload = {8'hD0, 8'(vi), 16'(k)};
            #1;
            chk($sformatf("v%0d_ren_wen_%0d", vi, k), {126'd0, dREN, dWEN},
                v.write ? 128'd1 : 128'd2);
            chk($sformatf("v%0d_daddr_%0d", vi, k), {96'd0, daddr}, {96'd0, v.exp_addr[k]});
            if (v.write)
                chk($sformatf("v%0d_dstore_%0d", vi, k), {96'd0, dstore}, {96'd0, v.exp_st[k]});
        end
        if (v.n_acc > 0) @(negedge CLK);
        dhit = 1'b0;
        #1;
        chk($sformatf("v%0d_done", vi), {125'd0, done, dREN, dWEN}, 128'd4);
        chk($sformatf("v%0d_ready_in_done", vi), {127'd0, req_ready}, 128'd0);
        @(negedge CLK);
        #1;
        chk($sformatf("v%0d_idle", vi), {126'd0, done, req_ready}, 128'd1);
        chk($sformatf("v%0d_rdata", vi), rdata, v.exp_rdata);
    endtask

    initial begin
        tv[0] = '{1'b0, 2'b00, 32'h100, 32'h0, '0, '0, 4'b1111, 4,
                  {32'h10C, 32'h108, 32'h104, 32'h100}, '0,
                  {32'hD0000003, 32'hD0000002, 32'hD0000001, 32'hD0000000}};
        tv[1] = '{1'b1, 2'b01, 32'hFFFFFFF8, 32'h8, '0,
                  {32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001, 32'hAAAA0000}, 4'b1011, 3,
                  {32'h0, 32'h10, 32'h0, 32'hFFFFFFF8},
                  {32'h0, 32'hAAAA0003, 32'hAAAA0001, 32'hAAAA0000},
                  {32'hD0000003, 32'hD0000002, 32'hD0000001, 32'hD0000000}};
        tv[2] = '{1'b0, 2'b10, 32'h0, 32'h0, {32'hC, 32'h8888, 32'h1234, 32'h40}, '0,
                  4'b0110, 2, {32'h0, 32'h0, 32'h8888, 32'h1234}, '0,
                  {32'hD0000003, 32'hD0020001, 32'hD0020000, 32'hD0000000}};
        tv[3] = '{1'b0, 2'b01, 32'h10, 32'hFFFFFFFC, '0, '0, 4'b1001, 2,
                  {32'h0, 32'h0, 32'h4, 32'h10}, '0,
                  {32'hD0030001, 32'hD0020001, 32'hD0020000, 32'hD0030000}};
        tv[4] = '{1'b1, 2'b00, 32'h7FFFFFF8, 32'h0, '0,
                  {32'hBBBB0003, 32'hBBBB0002, 32'hBBBB0001, 32'hBBBB0000}, 4'b0100, 1,
                  {32'h0, 32'h0, 32'h0, 32'h80000000}, {32'h0, 32'h0, 32'h0, 32'hBBBB0002},
                  {32'hD0030001, 32'hD0020001, 32'hD0020000, 32'hD0030000}};
        tv[5] = '{1'b0, 2'b00, 32'h0, 32'h0, '0, '0, 4'b0000, 0, '0, '0,
                  {32'hD0030001, 32'hD0020001, 32'hD0020000, 32'hD0030000}};

        nRST = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_mode = 2'b00;
        req_base = '0; req_stride = '0; req_addr = '0; req_wdata = '0; req_mask = '0;
        abort = 1'b0; dload = '0; dhit = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_ctl", {122'd0, req_ready, busy, done, dREN, dWEN, 1'b0}, 128'h20);
        chk("rst_daddr_dstore", {64'd0, daddr, dstore}, 128'd0);
        chk("rst_rdata", rdata, 128'd0);
        nRST = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(i);

        // GATHER load, single lane, three wait states before the hit
        drive_req(1'b0, 2'b10, 32'h0, 32'h0, {32'h1, 32'hABC0, 32'h2, 32'h3}, '0, 4'b0100);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge CLK);
            dhit  = (k == 3);
            dload = 32'h5555AAAA;
            #1;
            chk($sformatf("wait_ren_%0d", k), {125'd0, dREN, dWEN, done}, 128'd4);
            chk($sformatf("wait_daddr_%0d", k), {96'd0, daddr}, 128'hABC0);
        end
        @(negedge CLK); dhit = 1'b0; #1;
        chk("wait_done", {127'd0, done}, 128'd1);
        @(negedge CLK); #1;
        chk("wait_done_once", {127'd0, done}, 128'd0);
        chk("wait_rdata", rdata, {32'hD0030001, 32'h5555AAAA, 32'hD0020000, 32'hD0030000});

        // Abort raised while lane 1 waits: access held until hit, then idle
        drive_req(1'b0, 2'b00, 32'h200, 32'h0, '0, '0, 4'b1111);
        dhit = 1'b1; dload = 32'h11;
        @(negedge CLK);
        dhit = 1'b0; abort = 1'b1;
        #1 chk("abort_daddr", {95'd0, dREN, daddr}, {95'd1, 32'h204});
        @(negedge CLK);
        abort = 1'b0;
        #1 chk("abort_held", {95'd0, dREN, daddr}, {95'd1, 32'h204});
        @(negedge CLK);
        dhit = 1'b1; dload = 32'h22;
        #1 chk("abort_hit_addr", {96'd0, daddr}, 128'h204);
        @(negedge CLK);
        dhit = 1'b0;
        #1 chk("abort_idle", {124'd0, busy, done, dREN, req_ready}, 128'd1);
        @(negedge CLK); #1;
        chk("abort_no_done", {127'd0, done}, 128'd0);
        chk("abort_rdata", rdata, {32'hD0030001, 32'h5555AAAA, 32'h22, 32'h11});

        // Asynchronous reset in the middle of an op
        drive_req(1'b0, 2'b00, 32'h300, 32'h0, '0, '0, 4'b1111);
        dhit = 1'b1; dload = 32'h77;
        @(negedge CLK);
        dhit = 1'b0;
        #1 chk("pre_rst_busy", {126'd0, busy, dREN}, 128'd3);
        #1 nRST = 1'b0;
        #1;
        chk("async_rst_ctl", {124'd0, busy, dREN, dWEN, req_ready}, 128'd1);
        chk("async_rst_rdata", rdata, 128'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK); #1;
        chk("post_rst_idle", {126'd0, busy, req_ready}, 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
